sample_sequencer: RTL and testbench
===================================

SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 SHALL have parameter DIV, default 4: clk cycles per sample period; legal values are 2 or more.
REQ-002 SHALL have parameter WR_PHASE, default 2: divider phase of write_stb; legal range 0 to DIV-1.
REQ-003 SHALL have parameter INIT_CYCLES, default 3: idle clk cycles between start and the first read; legal values are 1 or more.
REQ-004 SHALL have parameter DRAIN_POINTS, default 1: extra write periods after the last read, covering DUT latency.
REQ-005 SHALL have parameters PTS_W, default 16, and ERR_W, default 16: point-counter width and error-counter width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port start, input, 1 bit: single-cycle request to begin a test vector.
REQ-009 SHALL have port num_points, input, PTS_W bits: vector length, sampled when start is accepted.
REQ-010 SHALL have port mismatch, input, 1 bit: actual-versus-expected compare result from the checker.
REQ-011 SHALL have port read_stb, output, 1 bit: fetch the next stimulus point.
REQ-012 SHALL have port write_stb, output, 1 bit: log outputs and sample mismatch.
REQ-013 SHALL have port point_idx, output, PTS_W bits: number of reads issued.
REQ-014 SHALL have port err_cnt, output, ERR_W bits: mismatches counted.
REQ-015 SHALL have port busy, output, 1 bit: high in INIT, RUN and DRAIN.
REQ-016 SHALL have port done, output, 1 bit: high while in DONE.

Function
REQ-017 SHALL implement FSM states IDLE, INIT, RUN, DRAIN and DONE.
REQ-018 SHALL, in IDLE or DONE, treat start=1 as accepted: latch num_points, clear point_idx, err_cnt and div_cnt, and go to INIT.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL stay in INIT for exactly INIT_CYCLES cycles, then go to RUN, or go directly to DONE if the latched num_points is 0.
REQ-021 SHALL run div_cnt from 0 to DIV-1 and wrap in RUN and DRAIN; div_cnt is 0 on the first RUN cycle.
REQ-022 SHALL pulse read_stb for one cycle when in RUN with div_cnt==0; point_idx increments on the cycle after each read_stb.
REQ-023 SHALL pulse write_stb for one cycle when in RUN or DRAIN with div_cnt==WR_PHASE.
REQ-024 SHALL leave RUN for DRAIN at the div_cnt wrap once point_idx equals num_points.
REQ-025 SHALL leave DRAIN for DONE after DRAIN_POINTS full periods, or immediately if DRAIN_POINTS is 0.
REQ-026 SHALL increment err_cnt when write_stb and mismatch are both 1, saturating at all-ones; mismatch is ignored at every other time.
REQ-027 SHALL hold point_idx and err_cnt stable in DONE until the next accepted start.
REQ-028 SHALL never assert read_stb and write_stb in the same cycle, which follows from the phase rules when WR_PHASE is not 0; WR_PHASE=0 is illegal.

Reset
REQ-029 SHALL, while rst_n=0, immediately place the FSM in IDLE and drive read_stb, write_stb, busy, done, point_idx, err_cnt and div_cnt to 0.
REQ-030 SHALL, when reset is asserted mid-vector, abort the vector with no further strobes; a new start is required after release.

Configuration
REQ-031 SHALL, with SEQ_ERR_STOP_EN defined, go straight from RUN or DRAIN to DONE on the cycle after the first counted mismatch, with no further strobes.
REQ-032 SHALL, without SEQ_ERR_STOP_EN, ignore mismatch for sequencing, so it affects err_cnt only.

Structure
REQ-033 SHALL place the state enum seq_state_t and the default parameter constants in package sample_sequencer_pkg.
REQ-034 SHALL use one sub-module, sample_divider, holding div_cnt, the wrap pulse and the phase compare; the FSM and counters stay in the top.

Verification
REQ-035 SHALL cover: defaults, num_points=3, start at cycle 0 -> reads at cycles 4, 8, 12; writes at 6, 10, 14, 18; done from cycle 20; point_idx=3.
REQ-036 SHALL cover: num_points=0 -> no strobes; done asserted 4 cycles after start.
REQ-037 SHALL cover: mismatch=1 at the writes at cycles 10 and 14 only -> err_cnt=2 at done; mismatch held at 1 between strobes adds nothing.
REQ-038 SHALL cover: start pulsed at cycle 9 -> ignored; start after done -> counters cleared and the sequence repeats identically.
REQ-039 SHALL cover: rst_n=0 at cycle 9 -> all outputs 0 within the same cycle; no strobes until a new start after release.
REQ-040 SHALL cover: SEQ_ERR_STOP_EN defined, mismatch at cycle 10 -> done from cycle 11; no read at 12; err_cnt=1.

Source files
------------

// File: rtl/sample_sequencer_pkg.sv
// Shared types and default parameter values for the sample sequencer.
// Optional feature macro used by the top: SEQ_ERR_STOP_EN.
package sample_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    localparam int DEF_DIV          = 4;
    localparam int DEF_WR_PHASE     = 2;
    localparam int DEF_INIT_CYCLES  = 3;
    localparam int DEF_DRAIN_POINTS = 1;
    localparam int DEF_PTS_W        = 16;
    localparam int DEF_ERR_W        = 16;

endpackage

// File: rtl/sample_sequencer_divider.sv
// Sample-period divider: free-running phase counter while enabled, held at 0 otherwise.
// Provides the period wrap pulse and the read/write phase compares.
module sample_divider #(
    parameter int DIV      = 4,
    parameter int WR_PHASE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_wrap,
    output logic o_rd_phase,
    output logic o_wr_phase
);

    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] r_div_cnt;
    logic             w_last;

    assign w_last = (r_div_cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (!i_en || w_last) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign o_wrap     = i_en & w_last;
    assign o_rd_phase = i_en & (r_div_cnt == '0);
    assign o_wr_phase = i_en & (r_div_cnt == CNT_W'(WR_PHASE));

endmodule

// File: rtl/sample_sequencer.sv
// Test-vector sequencer: issues read/write strobes per sample period and counts mismatches.
// Define SEQ_ERR_STOP_EN to end the vector on the first counted mismatch.
module sample_sequencer
    import sample_sequencer_pkg::*;
#(
    parameter int DIV          = DEF_DIV,
    parameter int WR_PHASE     = DEF_WR_PHASE,
    parameter int INIT_CYCLES  = DEF_INIT_CYCLES,
    parameter int DRAIN_POINTS = DEF_DRAIN_POINTS,
    parameter int PTS_W        = DEF_PTS_W,
    parameter int ERR_W        = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PTS_W-1:0] num_points,
    input  logic             mismatch,
    output logic             read_stb,
    output logic             write_stb,
    output logic [PTS_W-1:0] point_idx,
    output logic [ERR_W-1:0] err_cnt,
    output logic             busy,
    output logic             done
);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [PTS_W-1:0] r_num;
    logic [PTS_W-1:0] r_point_idx;
    logic [ERR_W-1:0] r_err_cnt;
    logic [31:0]      r_init_cnt;
    logic [31:0]      r_drain_cnt;

    logic w_en;
    logic w_wrap;
    logic w_rd_phase;
    logic w_wr_phase;
    logic w_read;
    logic w_write;
    logic w_accept;
    logic w_err_hit;
    logic w_init_last;
    logic w_drain_last;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign w_en = (r_state == S_RUN) || (r_state == S_DRAIN);

    sample_divider #(
        .DIV      (DIV),
        .WR_PHASE (WR_PHASE)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_en),
        .o_wrap     (w_wrap),
        .o_rd_phase (w_rd_phase),
        .o_wr_phase (w_wr_phase)
    );

    assign w_read       = (r_state == S_RUN) & w_rd_phase;
    assign w_write      = w_wr_phase;
    assign w_accept     = start & ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_err_hit    = w_write & mismatch;
    assign w_init_last  = (r_init_cnt == 32'(INIT_CYCLES - 1));
    assign w_drain_last = (r_drain_cnt == 32'(DRAIN_POINTS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) w_next = S_INIT;
            end
            S_INIT: begin
                if (w_init_last) w_next = (r_num == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                // Last read has already bumped point_idx by the time the period wraps.
                if (w_wrap && (r_point_idx == r_num)) begin
                    w_next = (DRAIN_POINTS == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_wrap && w_drain_last) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
`ifdef SEQ_ERR_STOP_EN
        if (w_err_hit) w_next = S_DONE;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num       <= '0;
            r_point_idx <= '0;
            r_err_cnt   <= '0;
            r_init_cnt  <= '0;
            r_drain_cnt <= '0;
        end else if (w_accept) begin
            r_num       <= num_points;
            r_point_idx <= '0;
            r_err_cnt   <= '0;
            r_init_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 1'b1;
            if ((r_state == S_DRAIN) && w_wrap) r_drain_cnt <= r_drain_cnt + 1'b1;
            if (w_read) r_point_idx <= r_point_idx + 1'b1;
            if (w_err_hit) r_err_cnt <= sat_inc(r_err_cnt);
        end
    end

    assign read_stb  = w_read;
    assign write_stb = w_write;
    assign point_idx = r_point_idx;
    assign err_cnt   = r_err_cnt;
    assign busy      = (r_state == S_INIT) || w_en;
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_sample_sequencer.sv
// Scoreboard bench for sample_sequencer: a period-level reference model queues expected
// strobe/done events per vector; an independent monitor pops and compares them.
module tb_sample_sequencer;

    localparam int DIV     = 4;
    localparam int WR      = 2;
    localparam int INIT    = 3;
    localparam int DRAIN   = 1;
    localparam int PTS_W   = 16;
    localparam int ERR_W   = 16;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [PTS_W-1:0] num_points = '0;
    logic             mismatch = 1'b0;
    logic             read_stb;
    logic             write_stb;
    logic [PTS_W-1:0] point_idx;
    logic [ERR_W-1:0] err_cnt;
    logic             busy;
    logic             done;

    sample_sequencer #(
        .DIV          (DIV),
        .WR_PHASE     (WR),
        .INIT_CYCLES  (INIT),
        .DRAIN_POINTS (DRAIN),
        .PTS_W        (PTS_W),
        .ERR_W        (ERR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_points (num_points),
        .mismatch   (mismatch),
        .read_stb   (read_stb),
        .write_stb  (write_stb),
        .point_idx  (point_idx),
        .err_cnt    (err_cnt),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int kind;   // 0 read, 1 write, 2 done
        int pidx;
        int err;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  n_pass = 0;
    int  n_total = 0;
    bit  mm_pat[64];
    bit  prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int c, input int k, input int p, input int e);
        ev_t ev;
        ev.cyc = c; ev.kind = k; ev.pidx = p; ev.err = e;
        q.push_back(ev);
    endtask

    // Reference: reads at the start of each of the first n periods, writes at phase WR of
    // each of the n+DRAIN periods, done right after the last period.
    task automatic model(input int s, input int n, output int done_at);
        int base, pidx, err, k, ph, per;
        base = s + INIT + 1;
        pidx = 0;
        err = 0;
        done_at = -1;
        per = n + DRAIN;
        if (n == 0) begin
            push(base, 2, 0, 0);
            done_at = base;
            return;
        end
        for (int t = base; t < s + 63 && done_at < 0; t++) begin
            k = (t - base) / DIV;
            ph = (t - base) % DIV;
            if (k >= per) begin
                push(t, 2, pidx, err);
                done_at = t;
            end else begin
                if (ph == 0 && k < n) begin
                    push(t, 0, pidx, 0);
                    pidx++;
                end
                if (ph == WR) begin
                    push(t, 1, 0, 0);
                    if (mm_pat[t - s]) begin
                        if (err < ERR_MAX) err++;
`ifdef SEQ_ERR_STOP_EN
                        push(t + 1, 2, pidx, err);
                        done_at = t + 1;
`endif
                    end
                end
            end
        end
    endtask

    task automatic check_ev(input int k);
        ev_t e;
        bit  ok;
        n_total++;
        if (q.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", k, cyc);
            return;
        end
        e = q.pop_front();
        ok = (e.kind == k) && (e.cyc == cyc);
        if (k == 0) ok = ok && (int'(point_idx) == e.pidx) && busy;
        if (k == 1) ok = ok && busy;
        if (k == 2) ok = ok && (int'(point_idx) == e.pidx) && (int'(err_cnt) == e.err);
        if (ok) n_pass++;
        else $display("FAIL event: got kind %0d cyc %0d pidx %0d err %0d busy %0b, expected kind %0d cyc %0d pidx %0d err %0d",
                      k, cyc, point_idx, err_cnt, busy, e.kind, e.cyc, e.pidx, e.err);
    endtask

    always @(negedge clk) begin
        if (read_stb) check_ev(0);
        if (write_stb) check_ev(1);
        if (done && !prev_done) check_ev(2);
        prev_done = done;
    end

    task automatic check_all_zero(input string tag);
        check_val({tag, "_read_stb"}, int'(read_stb), 0);
        check_val({tag, "_write_stb"}, int'(write_stb), 0);
        check_val({tag, "_busy"}, int'(busy), 0);
        check_val({tag, "_done"}, int'(done), 0);
        check_val({tag, "_point_idx"}, int'(point_idx), 0);
        check_val({tag, "_err_cnt"}, int'(err_cnt), 0);
    endtask

    // mode: 0 no mismatch, 1 random mismatch, 2 mismatch held over offsets 10..14
    task automatic run_vec(input int n, input int mode, input bit ign, input int abort_at);
        int s, done_at;
        @(negedge clk);
        s = cyc;
        for (int i = 0; i < 64; i++) begin
            case (mode)
                1:       mm_pat[i] = 1'($urandom_range(0, 1));
                2:       mm_pat[i] = (i >= 10 && i <= 14);
                default: mm_pat[i] = 1'b0;
            endcase
        end
        model(s, n, done_at);
        for (int off = 0; off <= done_at - s + 2; off++) begin
            if (off > 0) @(negedge clk);
            start = (off == 0) || (ign && off == 9);
            num_points = (off == 0) ? PTS_W'(n) : PTS_W'($urandom);
            mismatch = mm_pat[off];
            if (off == abort_at) begin
                #2 rst_n = 1'b0;
                q.delete();
                #1 check_all_zero("reset_mid_vector");
                start = 1'b0;
                mismatch = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (10) @(negedge clk);
                check_val("idle_after_reset_busy", int'(busy), 0);
                check_val("idle_after_reset_done", int'(done), 0);
                return;
            end
        end
        start = 1'b0;
        mismatch = 1'b0;
        check_val("events_drained", q.size(), 0);
        q.delete();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_vec(3, 0, 1'b0, -1);
        run_vec(0, 0, 1'b0, -1);
        run_vec(3, 2, 1'b1, -1);
        run_vec(3, 2, 1'b0, -1);
        run_vec(3, 0, 1'b0, 9);
        run_vec(3, 0, 1'b0, -1);
        for (int v = 0; v < 20; v++) begin
            int n;
            n = $urandom_range(0, 7);
            run_vec(n, 1, (n >= 1) && ($urandom_range(0, 1) == 1), -1);
        end
        repeat (3) @(negedge clk);
        check_val("final_queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
